// File: rtl/etu_stats_accum_if.sv
// Bundle between the per-neuron statistics accumulator and its driver/checker.
// The master side issues neurons and products and answers checkpoints.
interface etu_stats_accum_if #(
  parameter int DATA_W = 16,
  parameter int SQ_W   = 32,
  parameter int N_W    = 8
);
  logic                     start;
  logic [N_W-1:0]           total_len;
  logic [N_W-1:0]           e_step;
  logic                     prod_valid;
  logic signed [DATA_W-1:0] prod;
  logic                     prod_ready;
  logic                     stats_valid;
  logic signed [DATA_W-1:0] cum_val;
  logic [SQ_W-1:0]          cum_sq;
  logic [N_W-1:0]           n;
  logic                     etu_valid;
  logic                     etu_bit;
  logic                     done;
  logic                     early_out;
  logic signed [DATA_W-1:0] result;

  modport slave (
    input  start, total_len, e_step, prod_valid, prod, etu_valid, etu_bit,
    output prod_ready, stats_valid, cum_val, cum_sq, n, done, early_out, result
  );

  modport master (
    output start, total_len, e_step, prod_valid, prod, etu_valid, etu_bit,
    input  prod_ready, stats_valid, cum_val, cum_sq, n, done, early_out, result
  );
endinterface

// File: rtl/etu_stats_accum.sv
// Accumulates sum and sum-of-squares of one neuron's products, pausing every
// e_step products so an external confidence checker can request early termination.
module etu_stats_accum #(
  parameter int DATA_W = 16,
  parameter int SQ_W   = 32,
  parameter int N_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  etu_stats_accum_if.slave   bus_io
);

  localparam int PSQ_W = 2 * DATA_W;
  localparam int ACC_W = ((PSQ_W > SQ_W) ? PSQ_W : SQ_W) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, CHECK, FIN} state_t;

  function automatic logic signed [DATA_W-1:0] sat_add_val(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] s;
    s = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [SQ_W-1:0] sat_add_sq(
    input logic [SQ_W-1:0]  acc,
    input logic [PSQ_W-1:0] p2
  );
    logic [ACC_W-1:0] s;
    s = ACC_W'(acc) + ACC_W'(p2);
    if (s > ACC_W'({SQ_W{1'b1}}))
      return {SQ_W{1'b1}};
    return s[SQ_W-1:0];
  endfunction

  state_t                   state_q;
  logic [N_W-1:0]           len_q, estep_q, step_q, n_q;
  logic signed [DATA_W-1:0] cum_val_q, result_q;
  logic [SQ_W-1:0]          cum_sq_q;
  logic                     prod_ready_q, stats_valid_q, done_q, early_out_q;

  logic signed [PSQ_W-1:0]  prod_ext;
  logic [PSQ_W-1:0]         prod_sq;
  logic signed [DATA_W-1:0] cum_val_d;
  logic [SQ_W-1:0]          cum_sq_d;
  logic [N_W-1:0]           n_d, step_d;
  logic                     accept;

  // Square is taken at full 2*DATA_W width; it is always non-negative.
  always_comb begin
    prod_ext  = PSQ_W'(bus_io.prod);
    prod_sq   = $unsigned(prod_ext * prod_ext);
    cum_val_d = sat_add_val(cum_val_q, bus_io.prod);
    cum_sq_d  = sat_add_sq(cum_sq_q, prod_sq);
    n_d       = n_q + 1'b1;
    step_d    = step_q + 1'b1;
    accept    = bus_io.prod_valid && prod_ready_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      estep_q       <= '0;
      step_q        <= '0;
      n_q           <= '0;
      cum_val_q     <= '0;
      cum_sq_q      <= '0;
      result_q      <= '0;
      prod_ready_q  <= 1'b0;
      stats_valid_q <= 1'b0;
      done_q        <= 1'b0;
      early_out_q   <= 1'b0;
    end else begin
      stats_valid_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_io.start) begin
            len_q     <= bus_io.total_len;
            estep_q   <= bus_io.e_step;
            step_q    <= '0;
            n_q       <= '0;
            cum_val_q <= '0;
            cum_sq_q  <= '0;
            if (bus_io.total_len == '0) begin
              state_q     <= FIN;
              done_q      <= 1'b1;
              result_q    <= '0;
              early_out_q <= 1'b0;
            end else begin
              state_q      <= ACCUM;
              prod_ready_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            cum_val_q <= cum_val_d;
            cum_sq_q  <= cum_sq_d;
            n_q       <= n_d;
            step_q    <= step_d;
            // The final product wins over a coinciding checkpoint.
            if (n_d == len_q) begin
              state_q      <= FIN;
              prod_ready_q <= 1'b0;
              done_q       <= 1'b1;
              result_q     <= cum_val_d;
              early_out_q  <= 1'b0;
            end else if ((estep_q != '0) && (step_d == estep_q)) begin
              state_q       <= CHECK;
              step_q        <= '0;
              prod_ready_q  <= 1'b0;
              stats_valid_q <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (bus_io.etu_valid) begin
            if (bus_io.etu_bit) begin
              state_q     <= FIN;
              done_q      <= 1'b1;
              result_q    <= cum_val_q;
              early_out_q <= 1'b1;
            end else begin
              state_q      <= ACCUM;
              prod_ready_q <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q     <= IDLE;
          early_out_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.prod_ready  = prod_ready_q;
  assign bus_io.stats_valid = stats_valid_q;
  assign bus_io.cum_val     = cum_val_q;
  assign bus_io.cum_sq      = cum_sq_q;
  assign bus_io.n           = n_q;
  assign bus_io.done        = done_q;
  assign bus_io.early_out   = early_out_q;
  assign bus_io.result      = result_q;

endmodule

// File: tb/tb_etu_stats_accum.sv
// Scoreboard bench for etu_stats_accum: stimulus pushes expected stats/done
// records, an independent monitor pops and compares whenever the DUT emits one.
module tb_etu_stats_accum;
  localparam int DW = 16;
  localparam int SW = 32;
  localparam int NW = 8;

  typedef struct packed {
    logic signed [DW-1:0] cv;
    logic [SW-1:0]        sq;
    logic [NW-1:0]        n;
  } stats_exp_t;

  typedef struct packed {
    logic signed [DW-1:0] res;
    logic                 early;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  etu_stats_accum_if #(.DATA_W(DW), .SQ_W(SW), .N_W(NW)) bus ();

  etu_stats_accum #(.DATA_W(DW), .SQ_W(SW), .N_W(NW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int checks = 0;
  int errors = 0;
  stats_exp_t stats_q[$];
  done_exp_t  done_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic push_stats(input logic signed [DW-1:0] cv, input logic [SW-1:0] sq,
                            input logic [NW-1:0] nv);
    stats_exp_t e;
    e.cv = cv; e.sq = sq; e.n = nv;
    stats_q.push_back(e);
  endtask

  task automatic push_done(input logic signed [DW-1:0] res, input logic early);
    done_exp_t e;
    e.res = res; e.early = early;
    done_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (bus.stats_valid === 1'b1) begin
      if (stats_q.size() == 0) timeout_fail("unexpected_stats_valid");
      else begin
        stats_exp_t e;
        e = stats_q.pop_front();
        chk("stats", {8'h0, bus.cum_val, bus.cum_sq, bus.n}, {8'h0, e.cv, e.sq, e.n});
      end
    end
    if (bus.done === 1'b1) begin
      if (done_q.size() == 0) timeout_fail("unexpected_done");
      else begin
        done_exp_t e;
        e = done_q.pop_front();
        chk("done", {47'h0, bus.result, bus.early_out}, {47'h0, e.res, e.early});
      end
    end
  end

  task automatic start_neuron(input logic [NW-1:0] len, input logic [NW-1:0] e);
    bus.total_len = len;
    bus.e_step    = e;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic send_prod(input logic signed [DW-1:0] v);
    bit ok = 0;
    bus.prod       = v;
    bus.prod_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.prod_ready === 1'b1) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("prod_ready_timeout");
    @(posedge clk); #1;
    bus.prod_valid = 1'b0;
  endtask

  task automatic wait_stats();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.stats_valid === 1'b1) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("stats_valid_timeout");
  endtask

  task automatic respond(input logic b);
    bus.etu_valid = 1'b1;
    bus.etu_bit   = b;
    @(posedge clk); #1;
    bus.etu_valid = 1'b0;
    bus.etu_bit   = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_outputs"},
        {bus.prod_ready, bus.stats_valid, bus.done, bus.early_out, bus.cum_val,
         bus.cum_sq, bus.n, bus.result},
        64'h0);
  endtask

  initial begin
    bus.start = 0; bus.total_len = 0; bus.e_step = 0;
    bus.prod_valid = 0; bus.prod = 0; bus.etu_valid = 0; bus.etu_bit = 0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // No checking: plain sum
    push_done(16'sd9, 1'b0);
    start_neuron(8'd4, 8'd0);
    send_prod(16'sd3); send_prod(-16'sd1); send_prod(16'sd2); send_prod(16'sd5);
    wait_done();

    // Checkpoint at 4, continue, finish at 8
    push_stats(16'sd8, 32'd16, 8'd4);
    push_done(16'sd16, 1'b0);
    start_neuron(8'd8, 8'd4);
    for (int i = 0; i < 4; i++) send_prod(16'sd2);
    wait_stats();
    respond(1'b0);
    for (int i = 0; i < 4; i++) send_prod(16'sd2);
    wait_done();

    // Early termination, with spurious etu_valid in ACCUM and start in CHECK
    push_stats(16'sd8, 32'd16, 8'd4);
    push_done(16'sd8, 1'b1);
    start_neuron(8'd8, 8'd4);
    send_prod(16'sd2); send_prod(16'sd2);
    respond(1'b1);
    send_prod(16'sd2); send_prod(16'sd2);
    wait_stats();
    bus.start = 1'b1; bus.total_len = 8'd1; bus.e_step = 8'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("check_hold", {8'h0, bus.cum_val, bus.cum_sq, bus.n, bus.prod_ready},
        {8'h0, 16'sd8, 32'd16, 8'd4, 1'b0});
    respond(1'b1);
    @(negedge clk);
    chk("early_done_latency", {63'h0, bus.done}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ready_after_early", {63'h0, bus.prod_ready}, 64'h0);
    end
    @(posedge clk); #1;

    // Checkpoint coinciding with last product
    push_done(16'sd4, 1'b0);
    start_neuron(8'd4, 8'd4);
    for (int i = 0; i < 4; i++) send_prod(16'sd1);
    wait_done();

    // Zero-length neuron
    push_done(16'sd0, 1'b0);
    start_neuron(8'd0, 8'd3);
    wait_done();

    // Positive saturation of cum_val, exact cum_sq
    push_stats(16'sd32767, 32'd2147352578, 8'd2);
    push_done(16'sd32762, 1'b0);
    start_neuron(8'd3, 8'd2);
    send_prod(16'sd32767); send_prod(16'sd32767);
    wait_stats();
    respond(1'b0);
    send_prod(-16'sd5);
    wait_done();

    // Negative saturation and cum_sq saturation at 2^32-1
    push_stats(-16'sd32768, 32'hFFFF_FFFF, 8'd4);
    push_done(-16'sd32768, 1'b1);
    start_neuron(8'd5, 8'd4);
    for (int i = 0; i < 4; i++) send_prod(-16'sd32768);
    wait_stats();
    respond(1'b1);
    wait_done();

    // Reset while in CHECK
    push_stats(16'sd8, 32'd16, 8'd4);
    start_neuron(8'd8, 8'd4);
    for (int i = 0; i < 4; i++) send_prod(16'sd2);
    wait_stats();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_in_check");
    bus.etu_valid = 1'b1; bus.etu_bit = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("after_reset_idle");
    bus.etu_valid = 1'b0; bus.etu_bit = 1'b0;
    @(posedge clk); #1;

    // Fresh neuron after reset
    push_done(16'sd7, 1'b0);
    start_neuron(8'd1, 8'd0);
    send_prod(16'sd7);
    wait_done();

    repeat (3) @(posedge clk);
    chk("stats_queue_empty", 64'(stats_q.size()), 64'h0);
    chk("done_queue_empty", 64'(done_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
